// File: rtl/carrier_sense_detect_if.sv
// carrier_sense_detect_if
//   Groups the settings bus and the RX sample stream that feed carrier_sense_detect.
//   master : the side that drives the bus (RX DSP core / settings master / testbench)
//   slave  : carrier_sense_detect
//   Signals:
//     set_stb  - settings write strobe
//     set_addr - settings address (8 bits)
//     set_data - settings data (32 bits)
//     run_rx   - RX chain running
//     sample   - RX sample, [31:16] I, [15:0] Q, two's complement
//     strobe   - sample valid, one cycle per sample
interface carrier_sense_detect_if;
    logic        set_stb;
    logic [7:0]  set_addr;
    logic [31:0] set_data;
    logic        run_rx;
    logic [31:0] sample;
    logic        strobe;

    modport master (
        output set_stb, set_addr, set_data, run_rx, sample, strobe
    );

    modport slave (
        input set_stb, set_addr, set_data, run_rx, sample, strobe
    );
endinterface

// File: rtl/carrier_sense_detect.sv
// carrier_sense_detect
//   Receive-side power detector. Squares each RX sample, block-averages the
//   power over 2^log2win samples, and drives a hysteresis IDLE/BUSY decision
//   with a programmable holdoff measured in windows.
//   Ports:
//     clk                       - system clock
//     reset                     - asynchronous, active-high reset
//     bus                       - settings bus + RX sample stream (slave modport)
//     carrier_present           - channel busy
//     carrier_present_nextcount - windows remaining before busy may clear
//     debug                     - {busy, window_last, 6'b0, win_cnt, avg[31:16]}
//   Settings map (BASE+n): 0 thr_on, 1 thr_off, 2 holdoff,
//                          3 ctrl {log2win[11:8], enable[0]}
module carrier_sense_detect #(
    parameter int unsigned BASE = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    carrier_sense_detect_if.slave   bus,
    output logic                    carrier_present,
    output logic [31:0]             carrier_present_nextcount,
    output logic [31:0]             debug
);

    localparam logic [7:0] ADDR_THR_ON  = 8'(BASE + 0);
    localparam logic [7:0] ADDR_THR_OFF = 8'(BASE + 1);
    localparam logic [7:0] ADDR_HOLDOFF = 8'(BASE + 2);
    localparam logic [7:0] ADDR_CTRL    = 8'(BASE + 3);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Settings registers
    logic [31:0] r_thr_on;
    logic [31:0] r_thr_off;
    logic [31:0] r_holdoff;
    logic        r_enable;
    logic [3:0]  r_log2win;     // stored already clamped to 0..8

    // Datapath registers
    logic [31:0] r_pwr;
    logic        r_pwr_vld;
    logic [39:0] r_acc;
    logic [7:0]  r_win_cnt;
    logic [31:0] r_avg;
    logic        r_avg_valid;

    // Decision FSM
    state_t      r_state;
    logic [31:0] r_nextcount;

    logic               w_active;
    logic               w_ctrl_wr;
    logic [3:0]         w_log2win_new;
    logic signed [15:0] w_i;
    logic signed [15:0] w_q;
    logic signed [31:0] w_i2;
    logic signed [31:0] w_q2;
    logic [31:0]        w_pwr;
    logic [8:0]         w_win_len;
    logic [7:0]         w_win_max;
    logic               w_last;
    logic [39:0]        w_sum;
    logic [31:0]        w_avg;
    logic               w_unused_bits;

    assign w_active      = r_enable & bus.run_rx;
    assign w_ctrl_wr     = bus.set_stb && (bus.set_addr == ADDR_CTRL);
    assign w_log2win_new = (bus.set_data[11:8] > 4'd8) ? 4'd8 : bus.set_data[11:8];

    // Each square is at most 2^30, so the unsigned sum fits in 32 bits.
    assign w_i   = bus.sample[31:16];
    assign w_q   = bus.sample[15:0];
    assign w_i2  = w_i * w_i;
    assign w_q2  = w_q * w_q;
    assign w_pwr = 32'(w_i2) + 32'(w_q2);

    assign w_win_len = 9'd1 << r_log2win;
    assign w_win_max = 8'(w_win_len - 9'd1);
    assign w_last    = (r_win_cnt == w_win_max);

    // 256 * 2^31 = 2^39 fits in the 40-bit accumulator.
    assign w_sum = r_acc + 40'(r_pwr);
    assign w_avg = 32'(w_sum >> r_log2win);

    assign w_unused_bits = &{1'b0, bus.set_data[31:12], bus.set_data[7:1], r_avg[15:0]};

    // Settings bus and the two-stage power/averaging pipeline
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_thr_on    <= '0;
            r_thr_off   <= '0;
            r_holdoff   <= '0;
            r_enable    <= 1'b0;
            r_log2win   <= '0;
            r_pwr       <= '0;
            r_pwr_vld   <= 1'b0;
            r_acc       <= '0;
            r_win_cnt   <= '0;
            r_avg       <= '0;
            r_avg_valid <= 1'b0;
        end else begin
            if (bus.set_stb) begin
                if (bus.set_addr == ADDR_THR_ON)  r_thr_on  <= bus.set_data;
                if (bus.set_addr == ADDR_THR_OFF) r_thr_off <= bus.set_data;
                if (bus.set_addr == ADDR_HOLDOFF) r_holdoff <= bus.set_data;
                if (bus.set_addr == ADDR_CTRL) begin
                    r_enable  <= bus.set_data[0];
                    r_log2win <= w_log2win_new;
                end
            end

            // Stage 1: square. A sample here during a ctrl write survives
            // and lands in the freshly cleared window.
            r_pwr_vld <= w_active & bus.strobe;
            if (w_active && bus.strobe) begin
                r_pwr <= w_pwr;
            end

            // Stage 2: accumulate. Inactive or ctrl write clears and wins
            // over a coincident sample.
            r_avg_valid <= 1'b0;
            if (!w_active || w_ctrl_wr) begin
                r_acc     <= '0;
                r_win_cnt <= '0;
            end else if (r_pwr_vld) begin
                if (w_last) begin
                    r_avg       <= w_avg;
                    r_avg_valid <= 1'b1;
                    r_acc       <= '0;
                    r_win_cnt   <= '0;
                end else begin
                    r_acc     <= w_sum;
                    r_win_cnt <= r_win_cnt + 8'd1;
                end
            end
        end
    end

    // Decision FSM with hysteresis and holdoff; inactive clear has priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_nextcount <= '0;
        end else if (!w_active) begin
            r_state     <= IDLE;
            r_nextcount <= '0;
        end else if (r_avg_valid) begin
            case (r_state)
                IDLE: begin
                    if (r_avg >= r_thr_on) begin
                        r_state     <= BUSY;
                        r_nextcount <= r_holdoff;
                    end
                end
                BUSY: begin
                    if (r_avg >= r_thr_off) begin
                        r_nextcount <= r_holdoff;
                    end else if (r_nextcount == '0) begin
                        r_state <= IDLE;
                    end else begin
                        r_nextcount <= r_nextcount - 32'd1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_nextcount <= '0;
                end
            endcase
        end
    end

    assign carrier_present           = (r_state == BUSY);
    assign carrier_present_nextcount = r_nextcount;
    assign debug = {carrier_present, r_avg_valid, 6'b0, r_win_cnt, r_avg[31:16]};

endmodule

// File: doc/carrier_sense_detect.md
# carrier_sense_detect

Receive-side power detector that produces `carrier_present` and `carrier_present_nextcount` for `vita_tx_chain`. It squares and block-averages RX DSP samples, applies an on/off threshold with hysteresis, and holds the busy indication for a programmable number of windows after the power drops. It sits between `dsp_core_rx` output and the TX chain's carrier-sense inputs, configured over the standard settings bus.

## Interface
- `BASE`, 0: settings-bus base address; uses BASE+0..BASE+3.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `set_stb`  in  1  settings write strobe.
- `set_addr`  in  8  settings address.
- `set_data`  in  32  settings data.
- `run_rx`  in  1  RX chain running; detection is gated by it.
- `sample`  in  32  RX sample; [31:16] I, [15:0] Q, two's complement.
- `strobe`  in  1  sample valid, one cycle per sample.
- `carrier_present`  out  1  channel busy.
- `carrier_present_nextcount`  out  32  windows remaining before busy may clear; 0 when idle.
- `debug`  out  32  {busy, window_last, 6'b0, win_cnt[7:0], avg[31:16]}.

## Operation
- Registers (all reset to 0): BASE+0 `thr_on[31:0]`, BASE+1 `thr_off[31:0]`, BASE+2 `holdoff[31:0]` (in windows), BASE+3 `ctrl`: bit0 enable, bits[11:8] `log2win` (0..8; values >8 clamp to 8).
- A write to BASE+3 clears the accumulator and window counter; the next sample starts a new window.
- Active when `enable & run_rx`. Inactive: accumulator, window counter, busy, and nextcount are held at 0, and strobes are ignored. Deassertion mid-window discards the partial window.
- Stage 1: `pwr = I*I + Q*Q`, unsigned, 32 bits. The maximum is 2^31 at I=Q=-32768, so it never overflows.
- Stage 2: 40-bit `acc += pwr` per strobe. `win_cnt` counts 0..2^log2win-1. On the last sample of a window: `avg = (acc+pwr) >> log2win` (32 bits), `avg_valid` pulses, then `acc` and `win_cnt` are cleared.
- Decision FSM, states IDLE and BUSY, evaluated only on `avg_valid`:
  - IDLE -> BUSY when `avg >= thr_on`; load `nextcount = holdoff`.
  - BUSY with `avg >= thr_off`: reload `nextcount = holdoff`.
  - BUSY with `avg < thr_off`: if `nextcount == 0`, go to IDLE; else decrement `nextcount`.
  - With `holdoff = 0`, busy clears on the first window below `thr_off`.
- `carrier_present = (state == BUSY)`. In IDLE, `nextcount` is 0.
- `thr_off > thr_on` is legal and uses the same rules. `thr_on = 0` makes the block busy after the first window.
- Threshold and holdoff writes take effect at the next `avg_valid`; they do not restart the window.

## Timing
- Reset: all outputs 0, state IDLE, all registers 0.
- Settings writes take effect one cycle after the `set_stb` edge.
- Strobe presented at edge k:
  - `pwr` registered at k.
  - `acc` / `avg_valid` registered at k+1.
  - `carrier_present` / nextcount updated at k+2.
  - Latency from the last sample of a window to the output change is 3 clock edges.
- Back-to-back strobes (one per cycle) are supported at full rate, with no stall and no dropped samples.
- A ctrl write coinciding with a stage-2 strobe: the clear wins and that sample is discarded. A stage-1 sample in flight lands in the new window.
- `run_rx` falling coincident with `avg_valid`: the inactive clear wins, giving IDLE and nextcount 0 on the next edge.
- Asynchronous `reset` mid-window returns everything to reset values immediately. There is no recovery of partial state.

## Test plan
- Reset/idle: after reset, with strobes of I=1000,Q=0 and enable=0 -> `carrier_present` 0 and nextcount 0 throughout.
- Assert:
  - Setup: log2win=2, thr_on=500000, thr_off=250000, holdoff=3, enable=1, run_rx=1.
  - Stimulus: 4 strobes of I=1000,Q=0 (pwr 1e6).
  - Response: `carrier_present` rises 3 edges after the 4th strobe, with nextcount=3.
- Hysteresis/holdoff:
  - Stimulus: continue from the assert case with windows of I=600 (avg 360000, between thresholds).
  - Response: stays busy with nextcount=3.
  - Stimulus: then windows of I=0.
  - Response: nextcount goes 2, 1, 0, then `carrier_present` falls on the 4th zero window.
- Extremes: I=Q=-32768 at log2win=8 and thr_on=0x80000000 -> avg=0x80000000, busy asserts, and `acc` shows no wrap.
- Gating: `run_rx` dropped mid-BUSY -> next edge `carrier_present` 0 and nextcount 0. After re-raise, the first decision occurs only after a full new window.
- Ctrl restart: a ctrl write after 2 of 4 samples of I=1000, then 4 samples of I=0 -> remains IDLE, because the partial window was discarded.
